// File: rtl/battleship_pkg.sv
// Shared board types: cell encoding, queued write payload and scheduler states.
package battleship_pkg;

  localparam int unsigned BOARD_ROWS = 5;
  localparam int unsigned BOARD_COLS = 5;
  localparam int unsigned CELL_W     = 2;
  localparam int unsigned IDX_W      = $clog2(BOARD_ROWS * BOARD_COLS);

  typedef enum logic [CELL_W-1:0] {
    EMPTY = 2'd0,
    BOAT  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    cell_t            val;
  } wr_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/wr_fifo.sv
// Synchronous FIFO holding granted cell writes until vertical blanking.
module wr_fifo
  import battleship_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  wr_req_t                i_data,
  input  logic                   i_pop,
  output wr_req_t                o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wr_req_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/board_write_scheduler.sv
// Board cell store with two-requester write queue; commits only during vblank.
module board_write_scheduler
  import battleship_pkg::*;
#(
  parameter int unsigned ROWS   = BOARD_ROWS,
  parameter int unsigned COLS   = BOARD_COLS,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned CELLW  = CELL_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vblank,
  input  logic                      p_req,
  input  logic [$clog2(ROWS)-1:0]   p_row,
  input  logic [$clog2(COLS)-1:0]   p_col,
  input  logic [CELLW-1:0]          p_val,
  output logic                      p_gnt,
  input  logic                      c_req,
  input  logic [$clog2(ROWS)-1:0]   c_row,
  input  logic [$clog2(COLS)-1:0]   c_col,
  input  logic [CELLW-1:0]          c_val,
  output logic                      c_gnt,
  input  logic                      clear_req,
  output logic                      clear_done,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  output logic [CELLW-1:0]          rd_cell,
  output logic [$clog2(QDEPTH):0]   pending,
  output logic                      oob_err
);

  localparam int unsigned NCELLS = ROWS * COLS;
  localparam int unsigned RW     = $clog2(ROWS);
  localparam int unsigned CLW    = $clog2(COLS);
  localparam int unsigned CNTW   = $clog2(QDEPTH) + 1;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_prefer_p;
  logic                r_oob;
  logic                r_clear_pending;
  logic [IDX_W-1:0]    r_clear_idx;
  logic                r_clear_done;
  logic [CELLW-1:0]    r_cells [NCELLS];
  logic [CELLW-1:0]    r_rd_cell;

  logic                w_full;
  logic                w_empty;
  logic [CNTW-1:0]     w_count;
  wr_req_t             w_head;
  wr_req_t             w_push_data;
  logic                w_slot_free;
  logic                w_any_gnt;
  logic [RW-1:0]       w_sel_row;
  logic [CLW-1:0]      w_sel_col;
  logic [CELLW-1:0]    w_sel_val;
  logic                w_in_range;
  logic                w_push;
  logic                w_do_pop;
  logic                w_do_clear;
  logic                w_clear_last;
  logic                w_last_pop;
  logic                w_rd_in_range;
  logic [IDX_W-1:0]    w_rd_idx;

  // Round-robin grant; a slot is only offered against the registered count.
  assign w_slot_free = !w_full && !reset;
  assign p_gnt       = w_slot_free && p_req && (!c_req || r_prefer_p);
  assign c_gnt       = w_slot_free && c_req && (!p_req || !r_prefer_p);
  assign w_any_gnt   = p_gnt || c_gnt;

  // Payload of the granted requester and its range check.
  assign w_sel_row  = c_gnt ? c_row : p_row;
  assign w_sel_col  = c_gnt ? c_col : p_col;
  assign w_sel_val  = c_gnt ? c_val : p_val;
  assign w_in_range = (32'(w_sel_row) < ROWS) && (32'(w_sel_col) < COLS);
  assign w_push     = w_any_gnt && w_in_range;

  assign w_push_data.idx = IDX_W'(32'(w_sel_row) * COLS + 32'(w_sel_col));
  assign w_push_data.val = cell_t'(w_sel_val);

  assign w_clear_last = (r_clear_idx == IDX_W'(NCELLS - 1));
  assign w_last_pop   = (w_count == CNTW'(1)) && !w_push;

  wr_fifo #(
    .DEPTH (QDEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_do_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Arbitration pointer: the requester granted last loses the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_prefer_p <= 1'b1;
    else if (p_gnt) r_prefer_p <= 1'b0;
    else if (c_gnt) r_prefer_p <= 1'b1;
  end

  // Dropped out-of-range write flagged one cycle after its grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_oob <= 1'b0;
    else       r_oob <= w_any_gnt && !w_in_range;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and per-cycle commit actions; work starts on the first blank cycle.
  always_comb begin
    w_next_state = r_state;
    w_do_clear   = 1'b0;
    w_do_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        if (vblank && r_clear_pending) begin
          w_do_clear   = 1'b1;
          w_next_state = w_clear_last ? IDLE : CLEAR;
        end else if (vblank && !w_empty) begin
          w_do_pop     = 1'b1;
          w_next_state = w_last_pop ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (vblank && !w_empty) begin
          w_do_pop     = 1'b1;
          w_next_state = w_last_pop ? IDLE : DRAIN;
        end else begin
          w_next_state = IDLE;
        end
      end
      CLEAR: begin
        if (vblank) begin
          w_do_clear   = 1'b1;
          w_next_state = w_clear_last ? IDLE : CLEAR;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Clear bookkeeping: index survives blank gaps; new requests ignored while pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clear_pending <= 1'b0;
      r_clear_idx     <= '0;
      r_clear_done    <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      if (w_do_clear && w_clear_last) begin
        r_clear_pending <= 1'b0;
        r_clear_idx     <= '0;
        r_clear_done    <= 1'b1;
      end else begin
        if (w_do_clear) r_clear_idx     <= r_clear_idx + IDX_W'(1);
        if (clear_req)  r_clear_pending <= 1'b1;
      end
    end
  end

  // Cell store: one clear or one queued write per blank cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCELLS; i++) r_cells[i] <= '0;
    end else if (w_do_clear) begin
      r_cells[r_clear_idx] <= CELLW'(EMPTY);
    end else if (w_do_pop) begin
      r_cells[w_head.idx] <= CELLW'(w_head.val);
    end
  end

  assign w_rd_in_range = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
  assign w_rd_idx      = IDX_W'(32'(rd_row) * COLS + 32'(rd_col));

  // Registered display read; out-of-range addresses read EMPTY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_rd_cell <= '0;
    else if (w_rd_in_range) r_rd_cell <= r_cells[w_rd_idx];
    else                    r_rd_cell <= '0;
  end

  assign rd_cell    = r_rd_cell;
  assign pending    = w_count;
  assign oob_err    = r_oob;
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_board_write_scheduler.sv
// Directed bench for board_write_scheduler: arbitration, queueing, blank-gated commits, clear, reset.
module tb_board_write_scheduler;
  import battleship_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vblank = 1'b0;
  logic       p_req = 1'b0, c_req = 1'b0, clear_req = 1'b0;
  logic [2:0] p_row = '0, p_col = '0, c_row = '0, c_col = '0, rd_row = '0, rd_col = '0;
  logic [1:0] p_val = '0, c_val = '0;
  logic       p_gnt, c_gnt, clear_done, oob_err;
  logic [1:0] rd_cell;
  logic [2:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  board_write_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .vblank     (vblank),
    .p_req      (p_req),
    .p_row      (p_row),
    .p_col      (p_col),
    .p_val      (p_val),
    .p_gnt      (p_gnt),
    .c_req      (c_req),
    .c_row      (c_row),
    .c_col      (c_col),
    .c_val      (c_val),
    .c_gnt      (c_gnt),
    .clear_req  (clear_req),
    .clear_done (clear_done),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_cell    (rd_cell),
    .pending    (pending),
    .oob_err    (oob_err)
  );

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; vblank = 1'b0; p_req = 1'b0; c_req = 1'b0; clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Player write held until granted; bounded wait.
  task automatic p_write(input int r, input int c, input int v);
    bit got = 1'b0;
    p_row = 3'(r); p_col = 3'(c); p_val = 2'(v); p_req = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      got = p_gnt;
      @(posedge clk);
      #1;
    end
    p_req = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL p_write_timeout: no grant for (%0d,%0d)", r, c);
    end
  endtask

  task automatic read_cell(input int r, input int c, output logic [1:0] v);
    rd_row = 3'(r); rd_col = 3'(c);
    step();
    v = rd_cell;
  endtask

  task automatic test_reset();
    reset = 1'b1; p_req = 1'b1; c_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (p_gnt !== 1'b0 || c_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got p=%b c=%b exp 0 0", p_gnt, c_gnt); end
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d exp 0", pending); end
    n_tests++; if (rd_cell !== 2'd0 || clear_done !== 1'b0 || oob_err !== 1'b0) begin n_fail++; $display("FAIL reset_outs: rd=%0d done=%b oob=%b exp 0", rd_cell, clear_done, oob_err); end
    p_req = 1'b0; c_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic_write();
    logic [1:0] v;
    do_reset();
    p_row = 3'd2; p_col = 3'd3; p_val = BOAT; p_req = 1'b1;
    #1;
    n_tests++; if (p_gnt !== 1'b1 || c_gnt !== 1'b0) begin n_fail++; $display("FAIL basic_gnt: got p=%b c=%b exp 1 0", p_gnt, c_gnt); end
    step();
    p_req = 1'b0;
    n_tests++; if (pending !== 3'd1) begin n_fail++; $display("FAIL basic_pending1: got %0d exp 1", pending); end
    read_cell(2, 3, v);
    n_tests++; if (v !== 2'd0) begin n_fail++; $display("FAIL basic_no_commit: got %0d exp 0", v); end
    vblank = 1'b1;
    step();
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL basic_pending0: got %0d exp 0", pending); end
    n_tests++; if (rd_cell !== 2'd0) begin n_fail++; $display("FAIL basic_read_same_edge: got %0d exp 0", rd_cell); end
    step();
    n_tests++; if (rd_cell !== 2'd1) begin n_fail++; $display("FAIL basic_read_after: got %0d exp 1", rd_cell); end
    vblank = 1'b0;
  endtask

  task automatic test_round_robin();
    int pg = 0;
    int cg = 0;
    logic exp_p;
    logic [1:0] v;
    do_reset();
    p_req = 1'b1; c_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (pg == 0) begin p_row = 3'd0; p_col = 3'd0; p_val = BOAT; end
      else         begin p_row = 3'd1; p_col = 3'd1; p_val = HIT;  end
      if (cg == 0) begin c_row = 3'd0; c_col = 3'd1; c_val = HIT;  end
      else         begin c_row = 3'd1; c_col = 3'd1; c_val = MISS; end
      #1;
      exp_p = ((k % 2) == 0);
      n_tests++; if (p_gnt !== exp_p || c_gnt !== !exp_p) begin n_fail++; $display("FAIL rr_grant%0d: got p=%b c=%b exp p=%b c=%b", k, p_gnt, c_gnt, exp_p, !exp_p); end
      if (p_gnt) pg++;
      if (c_gnt) cg++;
      @(posedge clk);
      #1;
    end
    p_req = 1'b0; c_req = 1'b0;
    n_tests++; if (pending !== 3'd4) begin n_fail++; $display("FAIL rr_pending: got %0d exp 4", pending); end
    vblank = 1'b1;
    repeat (6) step();
    vblank = 1'b0;
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL rr_drained: got %0d exp 0", pending); end
    read_cell(1, 1, v);
    n_tests++; if (v !== 2'd3) begin n_fail++; $display("FAIL rr_cell11: got %0d exp 3", v); end
    read_cell(0, 0, v);
    n_tests++; if (v !== 2'd1) begin n_fail++; $display("FAIL rr_cell00: got %0d exp 1", v); end
    read_cell(0, 1, v);
    n_tests++; if (v !== 2'd2) begin n_fail++; $display("FAIL rr_cell01: got %0d exp 2", v); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] v;
    do_reset();
    p_row = 3'd0; p_val = BOAT; p_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p_col = 3'(k);
      #1;
      n_tests++; if (p_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt%0d: got %b exp 1", k, p_gnt); end
      @(posedge clk);
      #1;
    end
    p_col = 3'd4;
    #1;
    n_tests++; if (p_gnt !== 1'b0 || pending !== 3'd4) begin n_fail++; $display("FAIL b2b_full: got gnt=%b pending=%0d exp 0 4", p_gnt, pending); end
    @(posedge clk);
    #1;
    vblank = 1'b1;
    #1;
    n_tests++; if (p_gnt !== 1'b0) begin n_fail++; $display("FAIL b2b_first_pop_cycle: got %b exp 0", p_gnt); end
    @(posedge clk);
    #1;
    #1;
    n_tests++; if (p_gnt !== 1'b1 || pending !== 3'd3) begin n_fail++; $display("FAIL b2b_after_pop: got gnt=%b pending=%0d exp 1 3", p_gnt, pending); end
    @(posedge clk);
    #1;
    p_req = 1'b0;
    repeat (6) step();
    vblank = 1'b0;
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d exp 0", pending); end
    read_cell(0, 4, v);
    n_tests++; if (v !== 2'd1) begin n_fail++; $display("FAIL b2b_fifth: got %0d exp 1", v); end
  endtask

  task automatic test_clear();
    logic [1:0] v;
    int done_at = 0;
    int pulses = 0;
    do_reset();
    vblank = 1'b1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        p_write(r, c, 1);
    repeat (3) step();
    vblank = 1'b0;
    step();
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL clr_fill_pending: got %0d exp 0", pending); end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    vblank = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      if (clear_done) pulses++;
    end
    vblank = 1'b0;
    p_write(4, 4, 2);
    n_tests++; if (pending !== 3'd1) begin n_fail++; $display("FAIL clr_queued: got %0d exp 1", pending); end
    read_cell(0, 0, v);
    n_tests++; if (v !== 2'd0) begin n_fail++; $display("FAIL clr_cell0: got %0d exp 0", v); end
    read_cell(1, 4, v);
    n_tests++; if (v !== 2'd0) begin n_fail++; $display("FAIL clr_cell9: got %0d exp 0", v); end
    read_cell(2, 0, v);
    n_tests++; if (v !== 2'd1) begin n_fail++; $display("FAIL clr_cell10: got %0d exp 1", v); end
    read_cell(4, 4, v);
    n_tests++; if (v !== 2'd1) begin n_fail++; $display("FAIL clr_cell24_pre: got %0d exp 1", v); end
    vblank = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (clear_done) begin
        pulses++;
        if (done_at == 0) done_at = n;
      end
    end
    vblank = 1'b0;
    n_tests++; if (done_at !== 15) begin n_fail++; $display("FAIL clr_done_cycle: got %0d exp 15", done_at); end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL clr_done_pulses: got %0d exp 1", pulses); end
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL clr_post_pending: got %0d exp 0", pending); end
    read_cell(4, 4, v);
    n_tests++; if (v !== 2'd2) begin n_fail++; $display("FAIL clr_late_write: got %0d exp 2", v); end
    read_cell(2, 0, v);
    n_tests++; if (v !== 2'd0) begin n_fail++; $display("FAIL clr_cell10_post: got %0d exp 0", v); end
    read_cell(3, 3, v);
    n_tests++; if (v !== 2'd0) begin n_fail++; $display("FAIL clr_cell18_post: got %0d exp 0", v); end
  endtask

  task automatic test_oob();
    logic [1:0] v;
    int bad = 0;
    do_reset();
    p_row = 3'd5; p_col = 3'd0; p_val = BOAT; p_req = 1'b1;
    #1;
    n_tests++; if (p_gnt !== 1'b1) begin n_fail++; $display("FAIL oob_p_gnt: got %b exp 1", p_gnt); end
    @(posedge clk);
    #1;
    p_req = 1'b0;
    n_tests++; if (oob_err !== 1'b1 || pending !== 3'd0) begin n_fail++; $display("FAIL oob_p_flag: got oob=%b pending=%0d exp 1 0", oob_err, pending); end
    c_row = 3'd0; c_col = 3'd5; c_val = HIT; c_req = 1'b1;
    #1;
    n_tests++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL oob_c_gnt: got %b exp 1", c_gnt); end
    @(posedge clk);
    #1;
    c_req = 1'b0;
    n_tests++; if (oob_err !== 1'b1 || pending !== 3'd0) begin n_fail++; $display("FAIL oob_c_flag: got oob=%b pending=%0d exp 1 0", oob_err, pending); end
    step();
    n_tests++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL oob_pulse_end: got %b exp 0", oob_err); end
    vblank = 1'b1;
    repeat (4) step();
    vblank = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        read_cell(r, c, v);
        if (v !== 2'd0) bad++;
      end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL oob_board_untouched: got %0d nonzero cells exp 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] v;
    int pulses = 0;
    do_reset();
    vblank = 1'b1;
    p_write(4, 0, 1);
    repeat (2) step();
    vblank = 1'b0;
    p_write(1, 0, 2);
    p_write(1, 1, 2);
    n_tests++; if (pending !== 3'd2) begin n_fail++; $display("FAIL rst_mid_queued: got %0d exp 2", pending); end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    vblank = 1'b1;
    repeat (3) step();
    p_req = 1'b1; c_req = 1'b1; reset = 1'b1;
    #1;
    n_tests++; if (p_gnt !== 1'b0 || c_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_mid_gnt: got p=%b c=%b exp 0 0", p_gnt, c_gnt); end
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL rst_mid_pending: got %0d exp 0", pending); end
    @(posedge clk);
    #1;
    reset = 1'b0; p_req = 1'b0; c_req = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (clear_done) pulses++;
    end
    vblank = 1'b0;
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses exp 0", pulses); end
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL rst_mid_pending_after: got %0d exp 0", pending); end
    read_cell(4, 0, v);
    n_tests++; if (v !== 2'd0) begin n_fail++; $display("FAIL rst_mid_cell20: got %0d exp 0", v); end
    read_cell(1, 1, v);
    n_tests++; if (v !== 2'd0) begin n_fail++; $display("FAIL rst_mid_cell6: got %0d exp 0", v); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_round_robin();
    test_back_to_back();
    test_clear();
    test_oob();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
